// File: rtl/dac_spi_tx.sv
// Converts one signed Q(p.f) sample per strobe into a saturated 12-bit DAC code and
// shifts it out as a 16-bit SPI frame, MSB first; the DAC samples on falling dac_sclk.
module dac_spi_tx #(
  parameter int unsigned p       = 8,
  parameter int unsigned f       = 14,
  parameter int unsigned Width   = p + f + 1,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             enable,
  input  logic [Width-1:0] dato_dac,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic             dac_sync_n,
  output logic             dac_sclk,
  output logic             dac_din
);

  localparam int unsigned CODE_W  = 12;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);
  localparam int unsigned PH_W    = $clog2(2 * CLK_DIV);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t               state, state_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_nxt;
  logic [PH_W-1:0]      ph, ph_nxt;
  logic [FRAME_W-1:0]   frame, frame_nxt;
  logic [CODE_W-1:0]    code_c;
  logic                 busy_nxt, done_nxt, overrun_nxt;
  logic                 sync_n_nxt, sclk_nxt, din_nxt;
  logic                 unused_lsb;

  // Truncated fraction bits below the DAC resolution carry no information.
  assign unused_lsb = ^dato_dac[f-CODE_W-1:0];

  // Saturating conversion: negative clamps to zero, >= 1.0 clamps to full scale.
  always_comb begin
    code_c = dato_dac[f-1 -: CODE_W];
    if (dato_dac[Width-1]) begin
      code_c = '0;
    end else if (|dato_dac[Width-2:f]) begin
      code_c = '1;
    end
  end

  // Next state; outputs are derived from the next state so they register alongside it.
  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    ph_nxt    = ph;
    frame_nxt = frame;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = SHIFT;
          bit_nxt   = BIT_MSB;
          ph_nxt    = '0;
          frame_nxt = {{(FRAME_W-CODE_W){1'b0}}, code_c};
        end
      end
      SHIFT: begin
        if (ph == PH_LAST) begin
          ph_nxt = '0;
          if (bit_cnt == '0) begin
            state_nxt = GAP;
          end else begin
            bit_nxt = bit_cnt - BIT_W'(1);
          end
        end else begin
          ph_nxt = ph + PH_W'(1);
        end
      end
      GAP: begin
        if (ph == PH_LAST) begin
          state_nxt = IDLE;
          ph_nxt    = '0;
        end else begin
          ph_nxt = ph + PH_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        bit_nxt   = '0;
        ph_nxt    = '0;
      end
    endcase

    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = (state_nxt == GAP) && (ph_nxt == PH_LAST);
    overrun_nxt = enable && (state != IDLE);
    sync_n_nxt  = (state_nxt != SHIFT);
    sclk_nxt    = !((state_nxt == SHIFT) && (ph_nxt >= PH_HALF));
    din_nxt     = (state_nxt == SHIFT) && frame_nxt[bit_nxt];
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      ph         <= '0;
      frame      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      dac_sync_n <= 1'b1;
      dac_sclk   <= 1'b1;
      dac_din    <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_nxt;
      ph         <= ph_nxt;
      frame      <= frame_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      overrun    <= overrun_nxt;
      dac_sync_n <= sync_n_nxt;
      dac_sclk   <= sclk_nxt;
      dac_din    <= din_nxt;
    end
  end

endmodule
